// File: rtl/memory_mmio.sv
// Word-addressed RAM with two memory-mapped keyboard registers: a data register
// that pops a small key FIFO and a status register with count and overflow.
module memory_mmio #(
    parameter int          DATA_W    = 32,
    parameter int          RAM_AW    = 14,
    parameter int          FIFO_AW   = 3,
    parameter logic [31:0] KBD_ADDR  = 32'h0000_FFF0,
    parameter logic [31:0] STAT_ADDR = 32'h0000_FFF4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] WD,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic              sample,
    input  logic [7:0]        key_reg,
    output logic [DATA_W-1:0] RD,
    output logic              kbd_irq
);

    localparam int               DEPTH    = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

    logic [DATA_W-1:0]  ram [0:(1 << RAM_AW)-1];
    logic [7:0]         fifo [0:DEPTH-1];

    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW:0]   count;
    logic               overflow;

    logic               sync1;
    logic               sync2;
    logic               sync_prev;

    logic [RAM_AW-1:0]  ram_idx;
    logic               is_kbd;
    logic               is_stat;
    logic               ram_we;
    logic               fifo_empty;
    logic               fifo_full;
    logic               push_req;
    logic               pop;
    logic               push;
    logic               ovf_set;
    logic               ovf_clr;

    assign ram_idx    = addr[RAM_AW+1:2];
    assign is_kbd     = (addr == KBD_ADDR);
    assign is_stat    = (addr == STAT_ADDR);
    assign ram_we     = MemWrite && !is_kbd && !is_stat;

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign kbd_irq    = !fifo_empty;

    // Any level change of the synchronised key toggle is one new key.
    assign push_req   = sync2 ^ sync_prev;
    assign pop        = MemRead && !MemWrite && is_kbd && !fifo_empty;

    // A full FIFO still accepts a key when a pop frees the head slot in the same cycle.
    assign push       = push_req && (!fifo_full || pop);
    assign ovf_set    = push_req && fifo_full && !pop;
    assign ovf_clr    = MemWrite && is_stat && WD[15];

    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[ram_idx] <= WD;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wr_ptr] <= key_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync1     <= sample;
            sync2     <= sync1;
            sync_prev <= sync2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Setting wins over a software clear so a key lost in the clearing cycle is still reported.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

    always_comb begin
        RD = '0;
        if (is_kbd) begin
            if (!fifo_empty) begin
                RD[7:0] = fifo[rd_ptr];
            end
        end else if (is_stat) begin
            RD[15]        = overflow;
            RD[FIFO_AW:0] = count;
        end else begin
            RD = ram[ram_idx];
        end
    end

endmodule

// File: tb/tb_memory_mmio.sv
// Directed bench for memory_mmio: a RAM/decode vector table followed by
// hand-written keyboard FIFO sequences (latency, order, overflow, reset).
module tb_memory_mmio;

    localparam logic [31:0] KBD  = 32'h0000_FFF0;
    localparam logic [31:0] STAT = 32'h0000_FFF4;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] WD;
    logic        MemWrite;
    logic        MemRead;
    logic        sample;
    logic [7:0]  key_reg;
    logic [31:0] RD;
    logic        kbd_irq;

    int total;
    int bad;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
        logic        we;
        logic        re;
        logic        chk;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[$];

    memory_mmio #(
        .DATA_W   (32),
        .RAM_AW   (14),
        .FIFO_AW  (3),
        .KBD_ADDR (KBD),
        .STAT_ADDR(STAT)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr    (addr),
        .WD      (WD),
        .MemWrite(MemWrite),
        .MemRead (MemRead),
        .sample  (sample),
        .key_reg (key_reg),
        .RD      (RD),
        .kbd_irq (kbd_irq)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                                 input logic we, input logic re);
        addr     = a;
        WD       = d;
        MemWrite = we;
        MemRead  = re;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic addVec(input logic [31:0] a, input logic [31:0] d, input logic we,
                          input logic re, input logic chk, input logic [31:0] exp_rd);
        vec_t v;
        v.addr    = a;
        v.wd      = d;
        v.we      = we;
        v.re      = re;
        v.chk     = chk;
        v.exp_rd  = exp_rd;
        v.exp_irq = 1'b0;
        vecs.push_back(v);
    endtask

    task automatic checkStatus(input string name, input logic [31:0] exp);
        applyStimulus(STAT, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput(name, RD, exp);
    endtask

    // Toggle the key strobe and wait the three edges it takes to reach the FIFO.
    task automatic toggleKey(input logic [7:0] k);
        key_reg = k;
        sample  = ~sample;
        tick();
        tick();
        tick();
    endtask

    task automatic popExpect(input string name, input logic [7:0] k);
        applyStimulus(KBD, 32'h0, 1'b0, 1'b1);
        #1;
        checkOutput(name, RD, {24'h0, k});
        tick();
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] tail_keys [8];
        total    = 0;
        bad      = 0;
        clk      = 1'b0;
        rst_n    = 1'b1;
        sample   = 1'b0;
        key_reg  = 8'h00;
        applyStimulus(STAT, 32'h0, 1'b0, 1'b0);

        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_status", RD, 32'h0);
        checkOutput("reset_irq", {31'h0, kbd_irq}, 32'h0);
        #10 rst_n = 1'b1;
        tick();

        // RAM and address-decode vectors; expectations are the pre-edge RD value.
        addVec(32'h0000_0040, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 32'h0);
        addVec(32'h0000_0040, 32'h0,         1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF);
        addVec(32'h0000_0044, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 32'h0);
        addVec(32'h0000_0044, 32'h0,         1'b0, 1'b0, 1'b1, 32'h1234_5678);
        addVec(32'h0001_0040, 32'h0,         1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        addVec(32'h0001_FFF0, 32'hCAFE_F00D, 1'b1, 1'b0, 1'b0, 32'h0);
        addVec(32'h0001_FFF4, 32'h0BAD_C0DE, 1'b1, 1'b0, 1'b0, 32'h0);
        addVec(KBD,           32'hAAAA_5555, 1'b1, 1'b0, 1'b0, 32'h0);
        addVec(STAT,          32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0);
        addVec(32'h0001_FFF0, 32'h0,         1'b0, 1'b0, 1'b1, 32'hCAFE_F00D);
        addVec(32'h0001_FFF4, 32'h0,         1'b0, 1'b0, 1'b1, 32'h0BAD_C0DE);
        addVec(KBD,           32'h0,         1'b0, 1'b0, 1'b1, 32'h0);
        addVec(STAT,          32'h0,         1'b0, 1'b0, 1'b1, 32'h0);
        addVec(32'h8000_FFF0, 32'h1111_2222, 1'b1, 1'b0, 1'b0, 32'h0);
        addVec(32'h0001_FFF0, 32'h0,         1'b0, 1'b0, 1'b1, 32'h1111_2222);
        addVec(KBD,           32'h0,         1'b0, 1'b1, 1'b1, 32'h0);
        addVec(STAT,          32'h0,         1'b0, 1'b0, 1'b1, 32'h0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].addr, vecs[i].wd, vecs[i].we, vecs[i].re);
            #1;
            if (vecs[i].chk) begin
                checkOutput($sformatf("vec%0d_rd", i), RD, vecs[i].exp_rd);
                checkOutput($sformatf("vec%0d_irq", i), {31'h0, kbd_irq}, {31'h0, vecs[i].exp_irq});
            end
            tick();
        end
        applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);

        // Three keys, with the sample-to-irq latency checked on the first.
        key_reg = 8'h41;
        sample  = ~sample;
        tick();
        tick();
        checkOutput("latency_2edges_irq", {31'h0, kbd_irq}, 32'h0);
        tick();
        checkOutput("latency_3edges_irq", {31'h0, kbd_irq}, 32'h1);
        toggleKey(8'h42);
        toggleKey(8'h43);
        checkStatus("three_keys_status", 32'h0000_0003);
        checkOutput("three_keys_irq", {31'h0, kbd_irq}, 32'h1);
        popExpect("pop_0x41", 8'h41);
        popExpect("pop_0x42", 8'h42);
        popExpect("pop_0x43", 8'h43);
        popExpect("pop_empty", 8'h00);
        checkOutput("empty_irq", {31'h0, kbd_irq}, 32'h0);
        checkStatus("empty_status", 32'h0);

        // Holding the data address without MemRead must not pop; reset clears asynchronously.
        toggleKey(8'h51);
        toggleKey(8'h52);
        toggleKey(8'h53);
        toggleKey(8'h54);
        applyStimulus(KBD, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        checkOutput("hold_head", RD, 32'h51);
        checkStatus("hold_status", 32'h0000_0004);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_status", RD, 32'h0);
        checkOutput("async_reset_irq", {31'h0, kbd_irq}, 32'h0);
        #1 rst_n = 1'b1;

        // Seven toggles leave sample high, so the release must yield one key.
        tick();
        tick();
        checkOutput("post_reset_2edges_irq", {31'h0, kbd_irq}, 32'h0);
        tick();
        checkOutput("post_reset_push_irq", {31'h0, kbd_irq}, 32'h1);
        checkStatus("post_reset_status", 32'h0000_0001);
        popExpect("post_reset_key", 8'h54);
        checkOutput("post_reset_empty_irq", {31'h0, kbd_irq}, 32'h0);

        // Overflow: nine keys into eight slots.
        for (int i = 0; i < 9; i++) toggleKey(8'h60 + 8'(i));
        checkStatus("overflow_status", 32'h0000_8008);
        applyStimulus(KBD, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("overflow_head", RD, 32'h60);
        applyStimulus(STAT, 32'h0000_8000, 1'b1, 1'b0);
        tick();
        checkStatus("overflow_cleared", 32'h0000_0008);

        // Push and pop on the same edge while full.
        key_reg = 8'h70;
        sample  = ~sample;
        tick();
        tick();
        applyStimulus(KBD, 32'h0, 1'b0, 1'b1);
        #1;
        checkOutput("full_pushpop_head", RD, 32'h60);
        tick();
        checkStatus("full_pushpop_status", 32'h0000_0008);

        // Overflow set and software clear on the same edge: set must win.
        key_reg = 8'h71;
        sample  = ~sample;
        tick();
        tick();
        applyStimulus(STAT, 32'h0000_8000, 1'b1, 1'b0);
        tick();
        checkStatus("set_beats_clear", 32'h0000_8008);

        tail_keys = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h70};
        for (int i = 0; i < 8; i++) popExpect($sformatf("drain%0d", i), tail_keys[i]);
        checkOutput("drained_irq", {31'h0, kbd_irq}, 32'h0);
        checkStatus("drained_status", 32'h0000_8000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
